serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter WIDTH, default 4, number of data bits per frame (legal range 1..16).
REQ-002 Parameter DIV, default 1, clock cycles per serial bit (legal range 1..255).
REQ-003 Parameter PARITY, default 0: 0 = no parity bit, 1 = even parity bit.
REQ-004 ck  input  1  single clock; all state changes on rising edge.
REQ-005 res  input  1  reset, asynchronous, active-high.
REQ-006 din  input  WIDTH  parallel word to transmit, sampled only on an accepted load.
REQ-007 load  input  1  transmit request; accepted on a rising edge where load=1 and ready=1.
REQ-008 ready  output  1  high only in IDLE state; new load can be accepted.
REQ-009 so  output  1  serial line out, registered; drives downstream si input.
REQ-010 busy  output  1  high in every non-IDLE state.
REQ-011 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 States SHALL be IDLE, START, DATA, PAR, STOP; PAR exists only when PARITY=1.
REQ-013 Idle line level SHALL be so=0; start bit SHALL be 1; stop bit SHALL be 0.
REQ-014 On accepted load: din captured into internal shift buffer, state -> START, so=1 from that same edge.
REQ-015 Each bit state SHALL hold so constant for exactly DIV cycles, timed by a divider counter reloaded on every bit boundary.
REQ-016 DATA SHALL send WIDTH bits MSB first, din[WIDTH-1] down to din[0], tracked by a bit counter counting WIDTH-1 down to 0.
REQ-017 PAR bit SHALL equal XOR of captured word, making total ones across data+parity even.
REQ-018 Transitions at divider expiry: START->DATA; DATA (last bit)->PAR if PARITY=1 else STOP; PAR->STOP; STOP->IDLE.
REQ-019 Frame length SHALL be (WIDTH+2+PARITY)*DIV cycles from accepting edge to IDLE-entry edge.
REQ-020 done SHALL be 1 for exactly the one cycle following the STOP->IDLE edge, else 0.
REQ-021 load while busy=1 SHALL be ignored: no capture, no effect on current frame, not queued.
REQ-022 din changes after acceptance SHALL not affect the frame in progress.
REQ-023 Minimum one IDLE cycle between frames; load held high continuously SHALL start next frame on the first IDLE edge (done and ready both 1 in that cycle).
REQ-024 Divider and bit counters SHALL not wrap or count in IDLE.

Reset
REQ-025 res=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, so=0, busy=0, done=0, ready=1, counters and buffer cleared.
REQ-026 res asserted mid-frame SHALL abort the frame; no done pulse; after res falls, first edge with load=1 starts a fresh frame.
REQ-027 load during res=1 SHALL be ignored.

Verification
REQ-028 WIDTH=4, DIV=1, PARITY=0: din=4'b1011, load one cycle -> so per cycle 1,1,0,1,1,0 then 0; busy 6 cycles; done=1 on 7th cycle.
REQ-029 WIDTH=4, DIV=1, PARITY=1: din=4'b1011 -> so 1,1,0,1,1,1(parity),0; din=4'b0110 -> parity bit 0.
REQ-030 WIDTH=4, DIV=3: din=4'b0101 -> each bit held 3 cycles, frame 18 cycles, done after cycle 18.
REQ-031 load=1 and din changed every cycle during frame of 4'b1011 -> so sequence unchanged; second frame starts exactly on the done cycle with din present at that edge.
REQ-032 res pulsed (asynchronous, between edges) during DATA bit 2 -> so=0, busy=0 before next edge; no done; following load of 4'b1000 -> so 1,1,0,0,0,0.
REQ-033 Back-to-back, load held high with din=4'b1111 -> so 1,1,1,1,1,0,0(IDLE),1,... repeating, period 7 cycles.

Source files
------------

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Brief    : Parallel-load serial transmitter: start(1), WIDTH data bits MSB
//            first, optional even parity, stop(0); idle line level is 0.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int WIDTH  = 4,
    parameter int DIV    = 1,
    parameter int PARITY = 0
) (
    input  logic             ck,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int               c_BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]       c_DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0]       c_DIV_ONE  = 8'd1;
    localparam logic [c_BCW-1:0] c_BIT_LAST = c_BCW'(WIDTH - 1);
    localparam logic [c_BCW-1:0] c_BIT_ONE  = c_BCW'(1);
    localparam logic [c_BCW-1:0] c_BIT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par;
    logic [7:0]         r_div_cnt;
    logic [c_BCW-1:0]   r_bit_cnt;
    logic               r_so;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    logic               w_bit_end;
    logic [WIDTH-1:0]   w_shift_next;

    assign w_bit_end    = (r_div_cnt == 8'd0);
    assign w_shift_next = r_shift << 1;

    assign ready = r_ready;
    assign so    = r_so;
    assign busy  = r_busy;
    assign done  = r_done;

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_div_cnt <= 8'd0;
            r_bit_cnt <= c_BIT_ZERO;
            r_so      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Counters stay frozen here; they are reloaded on acceptance.
                    if (load) begin
                        r_shift   <= din;
                        r_par     <= ^din;
                        r_div_cnt <= c_DIV_LAST;
                        r_bit_cnt <= c_BIT_LAST;
                        r_so      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div_cnt <= c_DIV_LAST;
                        r_so      <= r_shift[WIDTH-1];
                        r_state   <= S_DATA;
                    end else begin
                        r_div_cnt <= r_div_cnt - c_DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div_cnt <= c_DIV_LAST;
                        if (r_bit_cnt == c_BIT_ZERO) begin
                            if (PARITY != 0) begin
                                r_so    <= r_par;
                                r_state <= S_PAR;
                            end else begin
                                r_so    <= 1'b0;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - c_BIT_ONE;
                            r_shift   <= w_shift_next;
                            r_so      <= w_shift_next[WIDTH-1];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - c_DIV_ONE;
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        r_div_cnt <= c_DIV_LAST;
                        r_so      <= 1'b0;
                        r_state   <= S_STOP;
                    end else begin
                        r_div_cnt <= r_div_cnt - c_DIV_ONE;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_so    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt - c_DIV_ONE;
                    end
                end
                default: begin
                    r_so    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
